// File: rtl/fetch_pc_sequencer_if.sv
// rtl/fetch_pc_sequencer_if.sv - IF-stage bundle between imem, redirect source, sequencer and decode
interface fetch_pc_sequencer_if #(
  parameter int XLEN        = 32,
  parameter int FETCH_BYTES = 8
);
  logic                     i_stall;
  logic                     i_redirect;
  logic [XLEN-1:0]          i_redirect_pc;
  logic                     i_fetch_valid;
  logic [8*FETCH_BYTES-1:0] i_fetch_data;
  logic [XLEN-1:0]          o_fetch_pc;
  logic                     o_instr_valid;
  logic [31:0]              o_instr;
  logic [XLEN-1:0]          o_instr_pc;
  logic                     o_instr_compressed;

  modport master (
    output i_stall, i_redirect, i_redirect_pc, i_fetch_valid, i_fetch_data,
    input  o_fetch_pc, o_instr_valid, o_instr, o_instr_pc, o_instr_compressed
  );

  modport slave (
    input  i_stall, i_redirect, i_redirect_pc, i_fetch_valid, i_fetch_data,
    output o_fetch_pc, o_instr_valid, o_instr, o_instr_pc, o_instr_compressed
  );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// rtl/fetch_pc_sequencer.sv - fetch PC / instruction PC sequencer with RVC parcel alignment
// Holds fetch-block address and instruction PC; buffers the low half of block-spanning 32-bit instrs.
module fetch_pc_sequencer #(
  parameter int          XLEN           = 32,
  parameter int          FETCH_BYTES    = 8,
  parameter int          HOLDOFF_CYCLES = 1,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  fetch_pc_sequencer_if.slave   bus
);
  localparam int OFFW = $clog2(FETCH_BYTES);
  localparam int CW   = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [XLEN-1:0] BLK_MASK = ~(XLEN'(FETCH_BYTES - 1));
  localparam logic [XLEN-1:0] FB_X     = XLEN'(FETCH_BYTES);
  localparam logic [XLEN-1:0] RST_PC   = XLEN'(RESET_PC);
  localparam logic [CW-1:0]   HOLD_INIT = CW'(HOLDOFF_CYCLES);

  if (FETCH_BYTES != 4 && FETCH_BYTES != 8 && FETCH_BYTES != 16) begin : g_bad_fetch_bytes
    $error("fetch_pc_sequencer: FETCH_BYTES must be 4, 8 or 16");
  end
  if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
    $error("fetch_pc_sequencer: HOLDOFF_CYCLES must be >= 1");
  end
  if (RESET_PC[0] != 1'b0) begin : g_bad_reset_pc
    $error("fetch_pc_sequencer: RESET_PC must be halfword aligned");
  end

  typedef enum logic [1:0] {
    ST_HOLDOFF = 2'd0,
    ST_RUN     = 2'd1,
    ST_SPAN    = 2'd2
  } state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [XLEN-1:0] r_pc, w_pc_nx;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nx;
  logic [15:0]     r_buf, w_buf_nx;

  // Zero-extended window so a 32-bit select at the last parcel never leaves the vector.
  logic [8*FETCH_BYTES+15:0] w_ext;
  logic [OFFW-1:0]           w_off;
  logic [31:0]               w_win;
  logic [15:0]               w_parcel;
  logic                      w_comp;
  logic                      w_fits;
  logic [XLEN-1:0]           w_len;
  logic [XLEN-1:0]           w_pc_adv;
  logic                      w_take;

  assign w_ext    = {16'b0, bus.i_fetch_data};
  assign w_off    = r_pc[OFFW-1:0];
  assign w_win    = w_ext[{w_off, 3'b000} +: 32];
  assign w_parcel = w_win[15:0];
  assign w_comp   = (w_parcel[1:0] != 2'b11);
  assign w_fits   = w_comp || (w_off <= OFFW'(FETCH_BYTES - 4));
  assign w_len    = w_comp ? XLEN'(2) : XLEN'(4);
  assign w_pc_adv = r_pc + ((r_state == ST_SPAN) ? XLEN'(4) : w_len);
  assign w_take   = bus.i_fetch_valid && !bus.i_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_HOLDOFF;
      r_cnt      <= HOLD_INIT;
      r_pc       <= RST_PC;
      r_fetch_pc <= RST_PC & BLK_MASK;
      r_buf      <= 16'h0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_pc       <= w_pc_nx;
      r_fetch_pc <= w_fetch_pc_nx;
      r_buf      <= w_buf_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_pc_nx       = r_pc;
    w_fetch_pc_nx = r_fetch_pc;
    w_buf_nx      = r_buf;
    if (bus.i_redirect) begin
      w_state_nx    = ST_HOLDOFF;
      w_cnt_nx      = HOLD_INIT;
      w_pc_nx       = bus.i_redirect_pc & ~XLEN'(1);
      w_fetch_pc_nx = bus.i_redirect_pc & BLK_MASK;
      w_buf_nx      = 16'h0;
    end else begin
      case (r_state)
        ST_HOLDOFF: begin
          // Holdoff models memory latency, so it runs down even while decode stalls.
          if (r_cnt == CW'(1)) w_state_nx = ST_RUN;
          else                 w_cnt_nx   = r_cnt - CW'(1);
        end
        ST_RUN: begin
          if (w_take) begin
            if (w_fits) begin
              w_pc_nx       = w_pc_adv;
              w_fetch_pc_nx = w_pc_adv & BLK_MASK;
            end else begin
              w_buf_nx      = w_parcel;
              w_state_nx    = ST_SPAN;
              w_fetch_pc_nx = (r_pc & BLK_MASK) + FB_X;
            end
          end
        end
        ST_SPAN: begin
          if (w_take) begin
            w_pc_nx       = w_pc_adv;
            w_fetch_pc_nx = w_pc_adv & BLK_MASK;
            w_state_nx    = ST_RUN;
          end
        end
        default: w_state_nx = ST_HOLDOFF;
      endcase
    end
  end

  always_comb begin
    bus.o_instr_valid      = 1'b0;
    bus.o_instr            = 32'h0;
    bus.o_instr_compressed = 1'b0;
    bus.o_instr_pc         = r_pc;
    bus.o_fetch_pc         = r_fetch_pc;
    if (!bus.i_redirect && bus.i_fetch_valid) begin
      if (r_state == ST_RUN && w_fits) begin
        bus.o_instr_valid      = 1'b1;
        bus.o_instr_compressed = w_comp;
        bus.o_instr            = w_comp ? {16'h0, w_parcel} : w_win;
      end else if (r_state == ST_SPAN) begin
        bus.o_instr_valid = 1'b1;
        bus.o_instr       = {bus.i_fetch_data[15:0], r_buf};
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb/tb_fetch_pc_sequencer.sv - directed self-checking bench for fetch_pc_sequencer
module tb_fetch_pc_sequencer;
  logic i_clk = 1'b0;
  logic i_rst_n;
  int   checks   = 0;
  int   failures = 0;

  fetch_pc_sequencer_if #(.XLEN(32), .FETCH_BYTES(8)) bus ();

  fetch_pc_sequencer #(
    .XLEN(32), .FETCH_BYTES(8), .HOLDOFF_CYCLES(1), .RESET_PC(32'h0)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [31:0] IA = 32'h1111_1113;
  localparam logic [31:0] IB = 32'h2222_2223;
  localparam logic [31:0] IC = 32'h3333_3333;
  localparam logic [31:0] ID = 32'h4444_4447;
  localparam logic [63:0] B0  = {IB, IA};
  localparam logic [63:0] B8  = {ID, IC};
  localparam logic [63:0] B2  = {IA, 16'h4002, 16'h0001};
  localparam logic [63:0] B3A = 64'h5553_0000_0000_0000;
  localparam logic [63:0] B3B = 64'h0000_0000_0001_6666;
  localparam logic [63:0] B4  = 64'h0000_0000_0002_0000;
  localparam logic [63:0] B6A = 64'h7773_0000_0000_0000;
  localparam logic [63:0] B6B = 64'h0000_0000_0000_8888;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ex(input string tag, input logic v, input logic [31:0] ins,
                    input logic [31:0] pc, input logic c, input logic [31:0] fpc);
    chk({tag, ".valid"}, 64'(bus.o_instr_valid), 64'(v));
    chk({tag, ".instr"}, 64'(bus.o_instr), 64'(ins));
    chk({tag, ".pc"}, 64'(bus.o_instr_pc), 64'(pc));
    chk({tag, ".comp"}, 64'(bus.o_instr_compressed), 64'(c));
    chk({tag, ".fpc"}, 64'(bus.o_fetch_pc), 64'(fpc));
  endtask

  task automatic set_in(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic fv, input logic [63:0] d);
    bus.i_stall       = st;
    bus.i_redirect    = rd;
    bus.i_redirect_pc = rpc;
    bus.i_fetch_valid = fv;
    bus.i_fetch_data  = d;
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic fv, input logic [63:0] d);
    set_in(st, rd, rpc, fv, d);
    @(negedge i_clk);
  endtask

  task automatic adv();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    ex("reset", 0, 0, 0, 0, 0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // 32-bit-only stream from reset
    drive(0, 0, 0, 1, B0);  ex("t1_hold", 0, 0, 0, 0, 0);       adv();
    drive(0, 0, 0, 1, B0);  ex("t1_pc0", 1, IA, 0, 0, 0);       adv();
    drive(0, 0, 0, 1, B0);  ex("t1_pc4", 1, IB, 4, 0, 0);       adv();
    drive(0, 0, 0, 1, B8);  ex("t1_pc8", 1, IC, 8, 0, 8);       adv();
    drive(0, 0, 0, 1, B8);  ex("t1_pcC", 1, ID, 32'hC, 0, 8);   adv();
    drive(0, 0, 0, 0, 0);   ex("t1_end", 0, 0, 32'h10, 0, 32'h10); adv();

    // mixed compressed block, with a 3-cycle stall at pc 4
    drive(0, 1, 0, 1, B8);  ex("t2_redir", 0, 0, 32'h10, 0, 32'h10); adv();
    drive(0, 0, 0, 1, B2);  ex("t2_hold", 0, 0, 0, 0, 0);       adv();
    drive(0, 0, 0, 1, B2);  ex("t2_pc0", 1, 32'h1, 0, 1, 0);    adv();
    drive(0, 0, 0, 1, B2);  ex("t2_pc2", 1, 32'h4002, 2, 1, 0); adv();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, B2); ex("t5_stall", 1, IA, 4, 0, 0);    adv();
    end
    drive(0, 0, 0, 1, B2);  ex("t2_pc4", 1, IA, 4, 0, 0);       adv();
    drive(0, 0, 0, 0, 0);   ex("t2_end", 0, 0, 8, 0, 8);        adv();

    // block-spanning 32-bit instruction at 0x6, valid gap inside SPAN
    drive(0, 1, 6, 0, 0);   ex("t3_redir", 0, 0, 8, 0, 8);      adv();
    drive(0, 0, 0, 1, B3A); ex("t3_hold", 0, 0, 6, 0, 0);       adv();
    drive(0, 0, 0, 1, B3A); ex("t3_span", 0, 0, 6, 0, 0);       adv();
    drive(0, 0, 0, 0, B3B); ex("t3_fv0", 0, 0, 6, 0, 8);        adv();
    drive(0, 0, 0, 1, B3B); ex("t3_join", 1, 32'h6666_5553, 6, 0, 8); adv();
    drive(0, 0, 0, 1, B3B); ex("t3_pcA", 1, 32'h1, 32'hA, 1, 8); adv();

    // redirect while in SPAN and stalled drops the buffered half
    drive(0, 1, 6, 1, B3B); ex("t4_redir0", 0, 0, 32'hC, 0, 8); adv();
    drive(0, 0, 0, 1, B3A); ex("t4_hold", 0, 0, 6, 0, 0);       adv();
    drive(0, 0, 0, 1, B3A); ex("t4_span", 0, 0, 6, 0, 0);       adv();
    drive(1, 1, 32'h102, 1, B3B); ex("t4_redir", 0, 0, 6, 0, 8); adv();
    drive(0, 0, 0, 1, B4);  ex("t4_hold2", 0, 0, 32'h102, 0, 32'h100); adv();
    drive(0, 0, 0, 1, B4);  ex("t4_pc102", 1, 32'h2, 32'h102, 1, 32'h100); adv();

    // span across the top of the address space wraps to block 0
    drive(0, 1, 32'hFFFF_FFFE, 0, 0); ex("t6_redir", 0, 0, 32'h104, 0, 32'h100); adv();
    drive(0, 0, 0, 1, B6A); ex("t6_hold", 0, 0, 32'hFFFF_FFFE, 0, 32'hFFFF_FFF8); adv();
    drive(0, 0, 0, 1, B6A); ex("t6_span", 0, 0, 32'hFFFF_FFFE, 0, 32'hFFFF_FFF8); adv();
    drive(0, 0, 0, 0, B6B); ex("t6_fv0", 0, 0, 32'hFFFF_FFFE, 0, 0); adv();
    drive(0, 0, 0, 1, B6B); ex("t6_join", 1, 32'h8888_7773, 32'hFFFF_FFFE, 0, 0); adv();
    drive(0, 0, 0, 0, 0);   ex("t6_wrap", 0, 0, 2, 0, 0);       adv();

    // asynchronous reset while in SPAN
    drive(0, 1, 6, 0, 0);   adv();
    drive(0, 0, 0, 1, B3A); adv();
    drive(0, 0, 0, 1, B3A); adv();
    drive(0, 0, 0, 0, 0);   ex("rst_pre", 0, 0, 6, 0, 8);
    #2 i_rst_n = 1'b0;
    #1 ex("rst_async", 0, 0, 0, 0, 0);
    adv();
    i_rst_n = 1'b1;
    drive(0, 0, 0, 1, B0);  ex("rst_hold", 0, 0, 0, 0, 0);      adv();
    drive(0, 0, 0, 1, B0);  ex("rst_pc0", 1, IA, 0, 0, 0);      adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
